// File: rtl/text_map_engine.sv
// rtl/text_map_engine.sv - fill/scroll sequencer and CPU arbiter for the text-map BRAM port a
module text_map_engine #(
  parameter int COLS = 80,
  parameter int ROWS = 30,
  parameter int AW   = $clog2(COLS*ROWS)
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic          cmd_op_i,
  input  logic [AW-1:0] cmd_start_i,
  input  logic [AW-1:0] cmd_len_i,
  input  logic [7:0]    cmd_ch_i,
  input  logic [7:0]    cmd_col_i,
  output logic          busy_o,
  output logic          done_o,
  input  logic          cpu_req_i,
  input  logic          cpu_we_i,
  input  logic          cpu_sel_i,
  input  logic [AW-1:0] cpu_addr_i,
  input  logic [7:0]    cpu_wdata_i,
  output logic [7:0]    cpu_rdata_o,
  output logic          cpu_rvalid_o,
  output logic [AW-1:0] ch_addr_o,
  output logic [AW-1:0] col_addr_o,
  output logic [7:0]    ch_wdata_o,
  output logic [7:0]    col_wdata_o,
  output logic          ch_wen_o,
  output logic          col_wen_o,
  input  logic [7:0]    ch_rdata_i,
  input  logic [7:0]    col_rdata_i
);

  localparam logic [AW-1:0] LAST_CELL = AW'(COLS*ROWS-1);
  localparam logic [AW-1:0] LAST_ROW  = AW'(COLS*(ROWS-1));
  localparam logic [AW-1:0] SCR_END   = AW'(COLS*(ROWS-1)-1);
  localparam logic [AW-1:0] ROW_STEP  = AW'(COLS);
  localparam logic [AW-1:0] ONE       = AW'(1);

  typedef enum logic [2:0] {
    IDLE, FILL, SCR_RD, SCR_CAP, SCR_WR, SCR_FILL, DONE
  } state_t;

  state_t        state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic [AW-1:0] cnt, cnt_nx;
  logic [7:0]    fill_ch, fill_col;
  logic [7:0]    hold_ch, hold_col;
  logic          rd_valid, rd_sel;

  logic [AW-1:0] eng_addr;
  logic [7:0]    eng_ch_wdata, eng_col_wdata;
  logic          eng_wen;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state    <= IDLE;
      ptr      <= '0;
      cnt      <= '0;
      fill_ch  <= '0;
      fill_col <= '0;
      hold_ch  <= '0;
      hold_col <= '0;
      rd_valid <= 1'b0;
      rd_sel   <= 1'b0;
    end else begin
      state <= state_nx;
      ptr   <= ptr_nx;
      cnt   <= cnt_nx;
      if (state == IDLE && cmd_valid_i) begin
        fill_ch  <= cmd_ch_i;
        fill_col <= cmd_col_i;
      end
      // rdata here answers the SCR_RD read, regardless of any CPU access now
      if (state == SCR_CAP) begin
        hold_ch  <= ch_rdata_i;
        hold_col <= col_rdata_i;
      end
      rd_valid <= cpu_req_i & ~cpu_we_i;
      rd_sel   <= cpu_sel_i;
    end
  end

  always_comb begin
    state_nx      = state;
    ptr_nx        = ptr;
    cnt_nx        = cnt;
    eng_addr      = '0;
    eng_ch_wdata  = '0;
    eng_col_wdata = '0;
    eng_wen       = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_valid_i) begin
          if (cmd_op_i) begin
            state_nx = SCR_RD;
            ptr_nx   = '0;
          end else if (cmd_len_i == '0) begin
            state_nx = DONE;
          end else begin
            state_nx = FILL;
            ptr_nx   = cmd_start_i;
            cnt_nx   = cmd_len_i;
          end
        end
      end
      FILL, SCR_FILL: begin
        eng_addr      = ptr;
        eng_ch_wdata  = fill_ch;
        eng_col_wdata = fill_col;
        eng_wen       = 1'b1;
        if (!cpu_req_i) begin
          // clamp at the last cell rather than wrapping
          if (ptr >= LAST_CELL || (state == FILL && cnt == ONE)) begin
            state_nx = DONE;
          end else begin
            ptr_nx = ptr + ONE;
            cnt_nx = cnt - ONE;
          end
        end
      end
      SCR_RD: begin
        eng_addr = ptr + ROW_STEP;
        if (!cpu_req_i) state_nx = SCR_CAP;
      end
      SCR_CAP: state_nx = SCR_WR;
      SCR_WR: begin
        eng_addr      = ptr;
        eng_ch_wdata  = hold_ch;
        eng_col_wdata = hold_col;
        eng_wen       = 1'b1;
        if (!cpu_req_i) begin
          if (ptr == SCR_END) begin
            state_nx = SCR_FILL;
            ptr_nx   = LAST_ROW;
          end else begin
            state_nx = SCR_RD;
            ptr_nx   = ptr + ONE;
          end
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign ch_addr_o    = cpu_req_i ? cpu_addr_i : eng_addr;
  assign col_addr_o   = cpu_req_i ? cpu_addr_i : eng_addr;
  assign ch_wdata_o   = cpu_req_i ? cpu_wdata_i : eng_ch_wdata;
  assign col_wdata_o  = cpu_req_i ? cpu_wdata_i : eng_col_wdata;
  assign ch_wen_o     = cpu_req_i ? (cpu_we_i & ~cpu_sel_i) : eng_wen;
  assign col_wen_o    = cpu_req_i ? (cpu_we_i & cpu_sel_i) : eng_wen;

  assign cpu_rvalid_o = rd_valid;
  assign cpu_rdata_o  = rd_valid ? (rd_sel ? col_rdata_i : ch_rdata_i) : 8'h00;

  assign cmd_ready_o  = (state == IDLE);
  assign busy_o       = (state != IDLE) && (state != DONE);
  assign done_o       = (state == DONE);

endmodule

// File: tb/tb_text_map_engine.sv
// tb/tb_text_map_engine.sv - directed bench for text_map_engine with a BRAM model on both maps
module tb_text_map_engine;
  localparam int COLS  = 80;
  localparam int ROWS  = 30;
  localparam int CELLS = COLS*ROWS;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_valid = 1'b0, cmd_op = 1'b0;
  logic [11:0] cmd_start = '0, cmd_len = '0;
  logic [7:0]  cmd_ch = '0, cmd_col = '0;
  logic        cmd_ready, busy, done;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_sel = 1'b0;
  logic [11:0] cpu_addr = '0;
  logic [7:0]  cpu_wdata = '0;
  logic [7:0]  cpu_rdata;
  logic        cpu_rvalid;
  logic [11:0] ch_addr, col_addr;
  logic [7:0]  ch_wdata, col_wdata;
  logic        ch_wen, col_wen;
  logic [7:0]  ch_rdata = '0, col_rdata = '0;

  always #5 clk = ~clk;

  text_map_engine dut (
    .clk_i(clk), .rstn_i(rstn),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_op_i(cmd_op),
    .cmd_start_i(cmd_start), .cmd_len_i(cmd_len), .cmd_ch_i(cmd_ch), .cmd_col_i(cmd_col),
    .busy_o(busy), .done_o(done),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_sel_i(cpu_sel), .cpu_addr_i(cpu_addr),
    .cpu_wdata_i(cpu_wdata), .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid),
    .ch_addr_o(ch_addr), .col_addr_o(col_addr), .ch_wdata_o(ch_wdata), .col_wdata_o(col_wdata),
    .ch_wen_o(ch_wen), .col_wen_o(col_wen), .ch_rdata_i(ch_rdata), .col_rdata_i(col_rdata)
  );

  // Registered-read BRAM model; preload is done by the same process to keep one writer.
  logic [7:0] ch_mem [CELLS];
  logic [7:0] col_mem[CELLS];
  logic       preload_req = 1'b0;
  int         preload_kind = 0;

  always @(posedge clk) begin
    if (preload_req) begin
      for (int i = 0; i < CELLS; i++) begin
        if (preload_kind == 0) begin
          ch_mem[i]  = 8'hEE;
          col_mem[i] = 8'hDD;
        end else begin
          ch_mem[i]  = 8'(i / COLS);
          col_mem[i] = 8'(128 + i / COLS);
        end
      end
    end else begin
      ch_rdata  <= ch_mem[ch_addr];
      col_rdata <= col_mem[col_addr];
      if (ch_wen)  ch_mem[ch_addr]   = ch_wdata;
      if (col_wen) col_mem[col_addr] = col_wdata;
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic preload(input int kind);
    @(negedge clk);
    preload_kind = kind;
    preload_req  = 1'b1;
    @(negedge clk);
    preload_req  = 1'b0;
  endtask

  task automatic issue(input logic op, input logic [11:0] start, input logic [11:0] len,
                       input logic [7:0] ch, input logic [7:0] col);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_start = start;
    cmd_len   = len;
    cmd_ch    = ch;
    cmd_col   = col;
    #1 check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
  endtask

  typedef struct {
    logic [11:0] start;
    logic [11:0] len;
    logic [7:0]  ch;
    logic [7:0]  col;
    int          exp_wr;
    int          exp_cyc;
  } fill_vec_t;

  fill_vec_t vecs[5];

  task automatic check_scroll(input string name);
    int bad;
    bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (i / COLS < ROWS - 1) begin
        if (ch_mem[i] !== 8'(i / COLS + 1) || col_mem[i] !== 8'(129 + i / COLS)) bad++;
      end else begin
        if (ch_mem[i] !== 8'h20 || col_mem[i] !== 8'h07) bad++;
      end
    end
    check(name, 32'(bad), 32'd0);
  endtask

  initial begin
    int cyc, nwr, first_addr, bad_wr, bad_busy, mism, wr_seen, done_seen;
    logic        due, pend;
    logic [7:0]  due_exp, pend_exp;

    vecs[0] = '{12'd100,  12'd5,  8'h41, 8'hF0, 5,  6};
    vecs[1] = '{12'd2398, 12'd10, 8'h42, 8'h1E, 2,  3};
    vecs[2] = '{12'd0,    12'd0,  8'h43, 8'h2D, 0,  1};
    vecs[3] = '{12'd0,    12'd1,  8'h44, 8'h3C, 1,  2};
    vecs[4] = '{12'd2390, 12'd10, 8'h45, 8'h4B, 10, 11};

    // reset held for three cycles
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_ctrl", {ch_wen, col_wen, busy, done, cpu_rvalid}, 5'b00000);
    check("reset_addr_data", {ch_addr, col_addr, ch_wdata, col_wdata, cpu_rdata}, '0);
    rstn = 1'b1;
    @(negedge clk); #1;
    check("ready_after_reset", {cmd_ready, busy}, 2'b10);

    // CPU single-cycle accesses while idle
    preload(0);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_sel = 1'b0; cpu_addr = 12'd7; cpu_wdata = 8'h5A;
    #1 check("cpu_wr_ch_ports", {ch_wen, col_wen, ch_addr, ch_wdata}, {2'b10, 12'd7, 8'h5A});
    @(negedge clk);
    cpu_sel = 1'b1; cpu_wdata = 8'hA5;
    #1 check("cpu_wr_col_ports", {ch_wen, col_wen, col_addr, col_wdata, cpu_rvalid}, {2'b01, 12'd7, 8'hA5, 1'b0});
    @(negedge clk);
    cpu_we = 1'b0; cpu_sel = 1'b0;
    #1 check("cpu_rd_no_wen", {ch_wen, col_wen}, 2'b00);
    @(negedge clk);
    cpu_sel = 1'b1;
    #1 check("cpu_rd_ch_data", {cpu_rvalid, cpu_rdata}, {1'b1, 8'h5A});
    @(negedge clk);
    cpu_req = 1'b0;
    #1 check("cpu_rd_col_data", {cpu_rvalid, cpu_rdata}, {1'b1, 8'hA5});
    @(negedge clk); #1;
    check("cpu_rvalid_drop", 32'(cpu_rvalid), 32'd0);

    // table-driven FILL vectors
    for (int v = 0; v < 5; v++) begin
      preload(0);
      issue(1'b0, vecs[v].start, vecs[v].len, vecs[v].ch, vecs[v].col);
      cyc = 0; nwr = 0; first_addr = -1; bad_wr = 0; bad_busy = 0;
      do begin
        @(negedge clk);
        cmd_valid = 1'b0;
        #1;
        cyc++;
        if (!done && !busy) bad_busy++;
        if (ch_wen || col_wen) begin
          if (nwr == 0) first_addr = int'(ch_addr);
          if (!(ch_wen && col_wen) || ch_addr !== 12'(int'(vecs[v].start) + nwr) ||
              col_addr !== ch_addr || ch_wdata !== vecs[v].ch || col_wdata !== vecs[v].col)
            bad_wr++;
          nwr++;
        end
      end while (!done && cyc < 100);
      check($sformatf("fill%0d_done_cycle", v), 32'(cyc), 32'(vecs[v].exp_cyc));
      check($sformatf("fill%0d_writes", v), 32'(nwr), 32'(vecs[v].exp_wr));
      check($sformatf("fill%0d_write_ports", v), 32'(bad_wr), 32'd0);
      check($sformatf("fill%0d_busy", v), {busy, 8'(bad_busy)}, '0);
      if (vecs[v].exp_wr > 0)
        check($sformatf("fill%0d_first_addr", v), 32'(first_addr), 32'(vecs[v].start));
      @(negedge clk); #1;
      check($sformatf("fill%0d_idle_after", v), {done, cmd_ready}, 2'b01);
      mism = 0;
      for (int a = int'(vecs[v].start); a < int'(vecs[v].start) + vecs[v].exp_wr; a++)
        if (ch_mem[a] !== vecs[v].ch || col_mem[a] !== vecs[v].col) mism++;
      if (int'(vecs[v].start) > 0)
        if (ch_mem[vecs[v].start - 1] !== 8'hEE || col_mem[vecs[v].start - 1] !== 8'hDD) mism++;
      if (int'(vecs[v].start) + vecs[v].exp_wr < CELLS)
        if (ch_mem[int'(vecs[v].start) + vecs[v].exp_wr] !== 8'hEE ||
            col_mem[int'(vecs[v].start) + vecs[v].exp_wr] !== 8'hDD) mism++;
      check($sformatf("fill%0d_mem", v), 32'(mism), 32'd0);
    end

    // reset asserted in the middle of a FILL
    preload(0);
    issue(1'b0, 12'd500, 12'd20, 8'h66, 8'h77);
    repeat (2) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk); #1;
    check("midreset_state", {ch_wen, col_wen, busy, done, cmd_ready}, 5'b00001);
    rstn = 1'b1;
    wr_seen = 0; done_seen = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (ch_wen || col_wen) wr_seen++;
      if (done) done_seen++;
    end
    check("midreset_no_writes", 32'(wr_seen), 32'd0);
    check("midreset_no_done", 32'(done_seen), 32'd0);
    check("midreset_ready", {cmd_ready, busy}, 2'b10);
    mism = 0;
    for (int a = 503; a < 520; a++)
      if (ch_mem[a] !== 8'hEE || col_mem[a] !== 8'hDD) mism++;
    check("midreset_mem_untouched", 32'(mism), 32'd0);
    check("midreset_mem_started", {ch_mem[500], col_mem[500]}, 16'h6677);

    // SCROLL_UP with no CPU traffic
    preload(1);
    issue(1'b1, 12'd0, 12'd0, 8'h20, 8'h07);
    cyc = 0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      #1;
      cyc++;
    end while (!done && cyc < 8000);
    check("scroll_done_cycle", 32'(cyc), 32'd7041);
    check("scroll_busy_at_done", 32'(busy), 32'd0);
    @(negedge clk); #1;
    check_scroll("scroll_mem");

    // SCROLL_UP with CPU reads in SCR_CAP (no stall), SCR_WR and SCR_RD (one stall each)
    preload(1);
    issue(1'b1, 12'd0, 12'd0, 8'h20, 8'h07);
    cyc = 0; pend = 1'b0; pend_exp = '0;
    do begin
      @(negedge clk);
      cmd_valid = 1'b0;
      cyc++;
      due = pend; due_exp = pend_exp;
      pend = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0;
      if (cyc == 2) begin
        cpu_req = 1'b1; cpu_sel = 1'b0; cpu_addr = 12'd5; pend = 1'b1; pend_exp = 8'h00;
      end else if (cyc == 6) begin
        cpu_req = 1'b1; cpu_sel = 1'b1; cpu_addr = 12'd5; pend = 1'b1; pend_exp = 8'h80;
      end else if (cyc == 8) begin
        cpu_req = 1'b1; cpu_sel = 1'b0; cpu_addr = 12'd85; pend = 1'b1; pend_exp = 8'h01;
      end
      #1;
      if (cyc == 6)
        check("stall_wr_ports_to_cpu", {ch_wen, col_wen, ch_addr}, {2'b00, 12'd5});
      if (due)
        check($sformatf("stall_cpu_read_c%0d", cyc - 1), {cpu_rvalid, cpu_rdata}, {1'b1, due_exp});
    end while (!done && cyc < 8000);
    check("stall_done_cycle", 32'(cyc), 32'd7043);
    @(negedge clk); #1;
    check_scroll("stall_scroll_mem");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule

// File: doc/text_map_engine.md
Name: text_map_engine

Overview:
- Command-driven fill/scroll engine and access arbiter for the port-a side of the character-map and colour-map BRAMs of the VGA text-mode controller (80x30 cells, 8-bit char code, 8-bit colour {fg[7:4], bg[3:0]}).
- Shares both map ports between a bus-side CPU requester (priority) and an internal sequencer that performs region fills and one-row scroll-up.
- Sits between the APB register block and the text-mode top.

Parameters:
COLS, 80, characters per row
ROWS, 30, rows per screen
AW, $clog2(COLS*ROWS) = 12, cell address width

Ports:
clk_i  in  1  system clock; all logic on rising edge
rstn_i  in  1  synchronous active-low reset
cmd_valid_i  in  1  command request
cmd_ready_o  out  1  engine idle, command accepted when valid&&ready
cmd_op_i  in  1  0 = FILL, 1 = SCROLL_UP
cmd_start_i  in  AW  FILL first cell
cmd_len_i  in  AW  FILL cell count
cmd_ch_i  in  8  fill character code
cmd_col_i  in  8  fill colour byte
busy_o  out  1  command in progress
done_o  out  1  one-cycle pulse on command completion
cpu_req_i  in  1  CPU access request, single cycle, always granted
cpu_we_i  in  1  1 = write
cpu_sel_i  in  1  0 = char map, 1 = colour map
cpu_addr_i  in  AW  cell address
cpu_wdata_i  in  8  write data
cpu_rdata_o  out  8  read data
cpu_rvalid_o  out  1  read data valid
ch_addr_o / col_addr_o  out  AW  map port-a addresses
ch_wdata_o / col_wdata_o  out  8  map write data
ch_wen_o / col_wen_o  out  1  map write enables
ch_rdata_i / col_rdata_i  in  8  map read data, registered, 1-cycle latency

Behaviour:
- Reset: state IDLE; outputs busy_o, done_o, cpu_rvalid_o, *_wen_o, addr/wdata and cpu_rdata_o all 0; cmd_ready_o = 1 on the first cycle after reset. Reset mid-command abandons it: no further writes and no done_o.
- Arbitration: when cpu_req_i = 1, that cycle's map ports carry the CPU access and the engine stalls, holding its state and counter. CPU write asserts only the selected map's wen. CPU read gives cpu_rvalid_o = 1 next cycle, with cpu_rdata_o = ch_rdata_i or col_rdata_i chosen by the registered sel.
- FSM states: IDLE, FILL, SCR_RD, SCR_CAP, SCR_WR, SCR_FILL, DONE.
- IDLE: cmd_ready_o = 1. On accept, latch all cmd fields and assert busy_o. Op FILL goes to FILL; SCROLL_UP goes to SCR_RD with ptr = 0.
- FILL: each non-stalled cycle writes cmd_ch/cmd_col to ptr on both maps, then ptr++. Ends after len writes or after writing cell COLS*ROWS-1, whichever comes first (clamp, no wrap). len = 0 goes straight to DONE with no writes.
- SCR_RD: issue a read of ptr+COLS on both maps (wen = 0); next state SCR_CAP. Stalls if cpu_req_i.
- SCR_CAP: unconditionally capture ch/col rdata into hold registers, even if cpu_req_i is high this cycle. Go to SCR_WR.
- SCR_WR: write the hold registers to ptr; stalls on cpu_req_i. Then ptr++. If ptr was COLS*(ROWS-1)-1, go to SCR_FILL with ptr = COLS*(ROWS-1); otherwise go to SCR_RD.
- SCR_FILL: fills the last row with cmd_ch/cmd_col like FILL, ending at COLS*ROWS-1.
- DONE: done_o = 1 for one cycle, busy_o = 0; next state IDLE. A new command is accepted no earlier than the cycle after DONE.
- Cycle counts with no CPU traffic, from the accept edge to done_o, exclusive: FILL = len + 1. SCROLL_UP = 3*COLS*(ROWS-1) + COLS + 1 = 7041.
- Address arithmetic is unsigned AW-bit. ptr+COLS never exceeds COLS*ROWS-1 in SCR_RD.
- cmd_valid_i while busy is ignored; the requester must hold it until ready.

Test Plan:
- Reset: hold rstn_i = 0 for 3 cycles -> all wen 0, busy_o 0, cmd_ready_o 1 after release.
- FILL start = 100, len = 5, ch = 0x41, col = 0xF0 -> cells 100..104 written on both maps on 5 consecutive cycles, done_o 6 cycles after accept. FILL start = 2398, len = 10 -> only 2398 and 2399 written.
- FILL len = 0 -> no wen, done_o on the cycle after accept.
- SCROLL_UP on a map preloaded with cell value = row index -> row r holds r+1 for r < 29, row 29 holds the fill char, done_o at 7041 cycles.
- CPU read of char cell 5 during SCROLL_UP, injected in the SCR_CAP cycle and again in an SCR_WR cycle -> cpu_rvalid_o next cycle with correct data, the scrolled result is still correct, and completion is delayed by exactly 1 cycle per stalling request.
- Reset asserted mid-FILL -> no writes after the reset edge, no done_o, engine idle and ready.
